// File: rtl/async_mem_req_frontend_if.sv
// async_mem_req_frontend_if
//   Request/response bus between a requester and async_mem_req_frontend.
//   master : requester side (drives req_valid/req_we/req_addr/req_wdata,
//            observes req_ready/rsp_valid/rsp_data)
//   slave  : front-end side (the mirror image)
//   Signals:
//     req_valid  request present
//     req_ready  front-end FIFO can accept
//     req_we     1 = write, 0 = read
//     req_addr   3-bit word address
//     req_wdata  3-bit write data
//     rsp_valid  one-cycle response pulse
//     rsp_data   16-bit read word, held until the next response
interface async_mem_req_frontend_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_addr;
   logic [2:0]  req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/async_mem_req_frontend.sv
// async_mem_req_frontend
//   Request front-end for the asynchronous SRAM controller. Requests are
//   buffered in a small FIFO and issued one at a time: EN pulses for one
//   cycle (ISSUE), then WE/addr/data_write are held for OP_CYCLES WAIT
//   cycles. Reads capture mem_rdata at WAIT count SAMPLE_CYCLE and return
//   it as a one-cycle rsp_valid pulse the cycle after the op completes.
//
//   Optional feature macro: ASYNC_FE_WRITE_ACK_EN
//     defined   : writes also pulse rsp_valid (rsp_data left unchanged)
//     undefined : only reads pulse rsp_valid
//
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     req        request/response bus (slave modport)
//     mem_en     controller EN, high only in ISSUE
//     mem_we     controller WE
//     mem_addr   controller addr
//     mem_wdata  controller data_write
//     mem_rdata  read word from the MemDB read path
//     busy       state not IDLE or FIFO non-empty
module async_mem_req_frontend #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned OP_CYCLES    = 10,
   parameter int unsigned SAMPLE_CYCLE = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   async_mem_req_frontend_if.slave   req,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [2:0]                mem_addr,
   output logic [2:0]                mem_wdata,
   input  logic [15:0]               mem_rdata,
   output logic                      busy
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_CYCLE);
   localparam logic [CW-1:0] LAST_AT   = CW'(OP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [6:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          full, empty, push, pop;

   logic [CW-1:0] cnt;
   logic          op_we;
   logic [2:0]    op_addr, op_wdata;
   logic          op_done, rsp_fire;
   logic          rsp_valid_q;
   logic [15:0]   rsp_data_q;

   // ---------------- FIFO ----------------
   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign req.req_ready = !full;
   assign push          = req.req_valid && !full;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {req.req_we, req.req_addr, req.req_wdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // ---------------- FSM ----------------
   assign op_done = (state == ST_WAIT) && (cnt == LAST_AT);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (cnt == LAST_AT)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef ASYNC_FE_WRITE_ACK_EN
   assign rsp_fire = op_done;
`else
   assign rsp_fire = op_done && !op_we;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mem_en      <= 1'b0;
         op_we       <= 1'b0;
         op_addr     <= '0;
         op_wdata    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state <= state_nxt;
         // EN is registered from the next state so it is high exactly
         // during the ISSUE cycle.
         mem_en <= (state_nxt == ST_ISSUE);
         if (pop)
            {op_we, op_addr, op_wdata} <= fifo_mem[rd_ptr];
         if (state == ST_ISSUE)
            cnt <= '0;
         else if ((state == ST_WAIT) && (cnt != LAST_AT))
            cnt <= cnt + 1'b1;
         if ((state == ST_WAIT) && (cnt == SAMPLE_AT) && !op_we)
            rsp_data_q <= mem_rdata;
         rsp_valid_q <= rsp_fire;
      end
   end

   assign mem_we       = op_we;
   assign mem_addr     = op_addr;
   assign mem_wdata    = op_wdata;
   assign req.rsp_valid = rsp_valid_q;
   assign req.rsp_data  = rsp_data_q;
   assign busy         = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_async_mem_req_frontend.sv
// tb_async_mem_req_frontend
//   Self-checking bench for async_mem_req_frontend. A request-queue model
//   with an operation timer predicts every output each cycle; directed
//   scenarios add latency, hold, ordering and reset checks, followed by a
//   randomized run with occasional asynchronous resets.
`timescale 1ns/1ps
module tb_async_mem_req_frontend;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned OPC   = 10;
   localparam int unsigned SMP   = 8;

   typedef struct packed {
      logic       we;
      logic [2:0] addr;
      logic [2:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_en, mem_we, busy;
   logic [2:0]  mem_addr, mem_wdata;
   logic [15:0] mem_rdata;

   async_mem_req_frontend_if bus ();

   async_mem_req_frontend #(
      .FIFO_DEPTH   (DEPTH),
      .OP_CYCLES    (OPC),
      .SAMPLE_CYCLE (SMP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // model state: pending requests, current op and its age in cycles
   // (0 = EN cycle, 1..OPC = WAIT cycles)
   req_t        q[$];
   req_t        cur;
   bit          act;
   int          t;
   bit          m_rsp;
   logic [15:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n = 0;
   int last_acc_cyc = -1;
   int last_rsp_cyc = -100;
   int rsp_cnt = 0;
   int en_cnt = 0;
   int hold_cnt = 0;
   req_t hold_ref;
   int          issue_cyc[$];
   logic [2:0]  issue_addr[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cur     = '0;
      act     = 1'b0;
      t       = 0;
      m_rsp   = 1'b0;
      m_rdata = '0;
   endtask

   task automatic compare();
      check("req_ready", bus.req_ready, q.size() < DEPTH);
      check("busy",      busy,          act || (q.size() != 0));
      check("mem_en",    mem_en,        act && (t == 0));
      check("mem_we",    mem_we,        cur.we);
      check("mem_addr",  mem_addr,      cur.addr);
      check("mem_wdata", mem_wdata,     cur.wdata);
      check("rsp_valid", bus.rsp_valid, m_rsp);
      check("rsp_data",  bus.rsp_data,  m_rdata);
      if (bus.rsp_valid) begin
         rsp_cnt++;
         last_rsp_cyc = cyc_n;
      end
      if (mem_en) begin
         en_cnt++;
         issue_cyc.push_back(cyc_n);
         issue_addr.push_back(mem_addr);
      end
      if (busy && ({mem_we, mem_addr, mem_wdata} == hold_ref))
         hold_cnt++;
   endtask

   task automatic advance();
      bit do_push;
      do_push = bus.req_valid && (q.size() < DEPTH);
      m_rsp = 1'b0;
      if (act) begin
         if ((t == SMP + 1) && !cur.we)
            m_rdata = mem_rdata;
         if (t == OPC) begin
            act = 1'b0;
`ifdef ASYNC_FE_WRITE_ACK_EN
            m_rsp = 1'b1;
`else
            m_rsp = !cur.we;
`endif
         end else begin
            t++;
         end
      end else if (q.size() != 0) begin
         cur = q.pop_front();
         act = 1'b1;
         t   = 0;
      end
      if (do_push) begin
         q.push_back(req_t'({bus.req_we, bus.req_addr, bus.req_wdata}));
         last_acc_cyc = cyc_n;
      end
   endtask

   // one clock cycle: check outputs, drive inputs, advance model
   task automatic cyc(input logic v, input logic we, input logic [2:0] a,
                      input logic [2:0] d, input logic [15:0] rd);
      compare();
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      mem_rdata     = rd;
      advance();
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
   endtask

   // asynchronous reset in the middle of a cycle
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mem_en",    mem_en,        1'b0);
      check("rst_busy",      busy,          1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_req_ready", bus.req_ready, 1'b1);
      model_reset();
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          acc;
      int          idx;
      int          stall;
      int          guard;
      logic [2:0]  alist [6];
      logic [15:0] rd;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      mem_rdata     = '0;
      hold_ref      = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rst_n = 1'b1;

      // single read of addr 5
      en_cnt = 0; rsp_cnt = 0; hold_cnt = 0;
      hold_ref = req_t'({1'b0, 3'd5, 3'd0});
      cyc(1'b1, 1'b0, 3'd5, 3'd0, 16'hA5C3);
      acc = last_acc_cyc;
      repeat (15) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'hA5C3);
      check("rd_latency", last_rsp_cyc - acc, 13);
      check("rd_en_pulses", en_cnt, 1);
      check("rd_hold", hold_cnt, 11);
      check("rd_rsp_cnt", rsp_cnt, 1);
      check("rd_data", bus.rsp_data, 16'hA5C3);

      // single write of addr 2, data 5
      rsp_cnt = 0; hold_cnt = 0;
      hold_ref = req_t'({1'b1, 3'd2, 3'd5});
      cyc(1'b1, 1'b1, 3'd2, 3'd5, 16'h0F0F);
      repeat (16) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'h0F0F);
      check("wr_hold", hold_cnt, 11);
`ifdef ASYNC_FE_WRITE_ACK_EN
      check("wr_rsp_cnt", rsp_cnt, 1);
`else
      check("wr_rsp_cnt", rsp_cnt, 0);
`endif
      check("wr_rsp_data", bus.rsp_data, 16'hA5C3);

      // requests with req_valid held high until the FIFO stalls
      alist[0] = 3'd1; alist[1] = 3'd3; alist[2] = 3'd6;
      alist[3] = 3'd0; alist[4] = 3'd7; alist[5] = 3'd4;
      issue_cyc.delete(); issue_addr.delete();
      idx = 0; stall = 0; guard = 0;
      while (idx < 6 && guard < 100) begin
         if (q.size() < DEPTH) begin
            cyc(1'b1, 1'b0, alist[idx], 3'd0, 16'($urandom));
            idx++;
         end else begin
            stall++;
            cyc(1'b1, 1'b0, alist[idx], 3'd0, 16'($urandom));
         end
         guard++;
      end
      check("burst_accepted", idx, 6);
      check("burst_stalled", stall > 0, 1'b1);
      repeat (90) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'($urandom));
      check("burst_issues", issue_addr.size(), 6);
      for (int i = 0; i < 6 && i < issue_addr.size(); i++) begin
         check("burst_order", issue_addr[i], alist[i]);
         if (i > 0)
            check("burst_spacing", issue_cyc[i] - issue_cyc[i-1], 12);
      end

      // reset during WAIT of a read with three queued
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, 3'(i + 1), 3'd0, 16'h1234);
      repeat (3) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'h1234);
      check("pre_rst_busy", busy, 1'b1);
      do_reset();
      rsp_cnt = 0;
      repeat (20) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'h1234);
      check("post_rst_rsp", rsp_cnt, 0);
      check("post_rst_ready", bus.req_ready, 1'b1);

      // mem_rdata changes right after the sample edge
      cyc(1'b1, 1'b0, 3'd4, 3'd0, 16'h1111);
      for (int i = 0; i < 16; i++) begin
         rd = (act && t > SMP + 1) ? 16'h2222 : 16'h1111;
         cyc(1'b0, 1'b0, 3'd0, 3'd0, rd);
      end
      check("sample_edge", bus.rsp_data, 16'h1111);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 599) == 0)
            do_reset();
         cyc(($urandom_range(0, 2) == 0), 1'($urandom), 3'($urandom),
             3'($urandom), 16'($urandom));
      end
      repeat (80) cyc(1'b0, 1'b0, 3'd0, 3'd0, 16'($urandom));
      check("final_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
